brlite_tx_arbiter: RTL
======================

// Module: brlite_tx_arbiter
// PURPOSE
// - Shares the single BrLite output port (br_req/br_ack/br_data) between N_REQ requesters: CPU MMR send path, monitor and kernel agents.
// - Round-robin arbitration.
// - Latches the winner's payload, holds the BrLite request until acknowledged, then returns a one-cycle ack to the winner.
// - Sits between the NI MMR block and the BrLite router local port.
// PARAMETERS
// - N_REQ           default 2    number of requesters, >=2
// - TIMEOUT_CYCLES  default 1024 BrLite ack watchdog limit; used only with BRLITE_ARB_TIMEOUT_EN; range 2..65535
// PORTS
// - clk_i         in   1                      clock, all logic on rising edge
// - rst_i         in   1                      reset, synchronous, active-high
// - req_i         in   N_REQ                  per-requester send request, level
// - data_i        in   N_REQ x brlite_out_t   per-requester payload (DMNIPkg)
// - ack_o         out  N_REQ                  per-requester completion pulse
// - br_local_busy_i in 1                      router local port busy; blocks new grants
// - br_req_o      out  1                      BrLite request to router
// - br_ack_i      in   1                      BrLite acknowledge from router
// - br_data_o     out  brlite_out_t           latched payload of current grant
// - busy_o        out  1                      1 when state != IDLE
// - grant_idx_o   out  $clog2(N_REQ)          index of current/last grant
// - timeout_o     out  1                      watchdog pulse; tied 0 without macro
// BEHAVIOUR
// - Reset values: br_req_o=0, br_data_o='0, ack_o='0, busy_o=0, grant_idx_o=0, timeout_o=0, state=IDLE.
// - Reset: RR pointer ptr=N_REQ-1, so requester 0 wins first.
// - Reset mid-transaction aborts it silently; no ack_o is issued.
// - FSM states: IDLE, REQ, RELEASE.
// - IDLE, condition: |req_i && !br_local_busy_i.
//   - Winner = first set req_i scanning ptr+1, ptr+2, ... modulo N_REQ.
//   - Next edge: br_data_o<=data_i[win]; grant_idx_o<=win; br_req_o<=1; ->REQ.
//   - Latency: req_i to br_req_o is 1 cycle.
// - IDLE with br_local_busy_i=1: no grant; requests wait.
// - REQ:
//   - br_req_o and br_data_o held stable. req_i changes and data_i changes are ignored; no abort.
//   - On br_ack_i=1: br_req_o<=0; ack_o[grant_idx_o]<=1; ptr<=grant_idx_o; ->RELEASE.
// - RELEASE: ack_o is high for exactly this cycle. Next edge: ack_o<=0; ->IDLE.
// - Requester rule:
//   - Hold req_i and data_i until ack_o is seen.
//   - Deassert req_i on the edge ending the ack cycle.
//   - A still-high req_i in IDLE is a new request.
// - br_ack_i outside REQ is ignored.
// - At most one ack_o bit is set at any time. Back-to-back grants: 3 cycles minimum per transfer (IDLE, REQ with immediate ack, RELEASE).
// - Fairness: a requester continuously asserting waits at most N_REQ-1 grants.
// - Index arithmetic is modulo N_REQ; N_REQ need not be a power of 2. Wrap from N_REQ-1 to 0 is explicit.
// CONFIGURATION
// - BRLITE_ARB_TIMEOUT_EN defined:
//   - 16-bit counter cleared on entry to REQ, incremented each REQ cycle without br_ack_i.
//   - When counter==TIMEOUT_CYCLES-1 and !br_ack_i: br_req_o<=0; timeout_o<=1 for one cycle; ack_o[grant] pulses (transfer dropped); ptr<=grant; ->RELEASE.
//   - br_ack_i in the same cycle as expiry: normal completion wins; no timeout_o.
// - BRLITE_ARB_TIMEOUT_EN undefined: no counter; REQ waits indefinitely; timeout_o constant 0.
// TESTING
// - Reset, then req_i=2'b01, data0.payload=32'hCAFE0001, br_ack_i one cycle after br_req_o
//   -> br_req_o high 1 cycle after req; br_data_o.payload=CAFE0001; ack_o=01 for 1 cycle; busy_o=0 after RELEASE.
// - req_i=2'b11 held, each ack after 2 cycles
//   -> grant order 0,1,0,1; grant_idx_o alternates; never two ack_o bits set.
// - N_REQ=3, req_i=3'b101 held
//   -> grants 0,2,0,2; requester 2 never starved; wrap-around 2->0 correct.
// - br_local_busy_i=1 for 5 cycles with req_i=01
//   -> br_req_o stays 0; goes high 1 cycle after busy drops.
// - In REQ, change data_i[0] and drop req_i[0]
//   -> br_data_o unchanged; transfer completes; ack_o[0] still pulses.
// - Macro on, TIMEOUT_CYCLES=8, br_ack_i never asserted
//   -> br_req_o drops after 8 REQ cycles; timeout_o and ack_o pulse once.
// - Same with br_ack_i arriving in the expiry cycle -> timeout_o stays 0.
// - rst_i asserted during REQ -> next cycle all outputs at reset values; no ack_o.

Source files
------------

// File: rtl/DMNIPkg.sv
`default_nettype none
// ============================================================================
//  Package : DMNIPkg
//  Shared NI/BrLite types used by the BrLite transmit path.
//  Revision: 1.0
// ============================================================================
package DMNIPkg;

   typedef struct packed {
      logic [7:0]  service;
      logic [15:0] seq_source;
      logic [31:0] payload;
   } brlite_out_t;

endpackage
`default_nettype wire

// File: rtl/brlite_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : brlite_tx_arbiter
//  Round-robin share of the BrLite local output port between N_REQ requesters.
//  Optional ack watchdog enabled by the macro BRLITE_ARB_TIMEOUT_EN.
//  Revision: 1.0
// ============================================================================
module brlite_tx_arbiter
   import DMNIPkg::*;
#(
   parameter int N_REQ          = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [N_REQ-1:0]         req_i,
   input  brlite_out_t              data_i [N_REQ],
   output logic [N_REQ-1:0]         ack_o,
   input  logic                     br_local_busy_i,
   output logic                     br_req_o,
   input  logic                     br_ack_i,
   output brlite_out_t              br_data_o,
   output logic                     busy_o,
   output logic [$clog2(N_REQ)-1:0] grant_idx_o,
   output logic                     timeout_o
);

   localparam int c_IDX_W = $clog2(N_REQ);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   state_t             state_q;
   logic [c_IDX_W-1:0] ptr_q;
   logic [c_IDX_W-1:0] grant_q;
   logic [N_REQ-1:0]   ack_q;
   logic               br_req_q;
   brlite_out_t        br_data_q;

   logic [c_IDX_W-1:0] w_win_idx;
   logic               w_win_vld;

`ifdef BRLITE_ARB_TIMEOUT_EN
   localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] tmo_cnt_q;
   logic        timeout_q;
`endif

   // Scan from the farthest candidate back to ptr+1 so the nearest set request wins.
   always_comb begin : p_pick
      int                 cand;
      logic [c_IDX_W-1:0] cand_idx;
      cand      = 0;
      cand_idx  = '0;
      w_win_idx = ptr_q;
      w_win_vld = 1'b0;
      for (int k = N_REQ; k >= 1; k--) begin
         cand = int'(ptr_q) + k;
         if (cand >= N_REQ) begin
            cand = cand - N_REQ;
         end
         cand_idx = c_IDX_W'(cand);
         if (req_i[cand_idx]) begin
            w_win_idx = cand_idx;
            w_win_vld = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         ptr_q     <= c_IDX_W'(N_REQ - 1);
         grant_q   <= '0;
         ack_q     <= '0;
         br_req_q  <= 1'b0;
         br_data_q <= '0;
`ifdef BRLITE_ARB_TIMEOUT_EN
         tmo_cnt_q <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         ack_q <= '0;
`ifdef BRLITE_ARB_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (w_win_vld && !br_local_busy_i) begin
                  br_data_q <= data_i[w_win_idx];
                  grant_q   <= w_win_idx;
                  br_req_q  <= 1'b1;
                  state_q   <= S_REQ;
`ifdef BRLITE_ARB_TIMEOUT_EN
                  tmo_cnt_q <= '0;
`endif
               end
            end
            S_REQ: begin
               if (br_ack_i) begin
                  br_req_q       <= 1'b0;
                  ack_q[grant_q] <= 1'b1;
                  ptr_q          <= grant_q;
                  state_q        <= S_RELEASE;
               end
`ifdef BRLITE_ARB_TIMEOUT_EN
               // Expiry drops the transfer but still releases the requester.
               else if (tmo_cnt_q == c_TMO_LAST) begin
                  br_req_q       <= 1'b0;
                  timeout_q      <= 1'b1;
                  ack_q[grant_q] <= 1'b1;
                  ptr_q          <= grant_q;
                  state_q        <= S_RELEASE;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 16'd1;
               end
`endif
            end
            S_RELEASE: state_q <= S_IDLE;
            default:   state_q <= S_IDLE;
         endcase
      end
   end

   assign ack_o       = ack_q;
   assign br_req_o    = br_req_q;
   assign br_data_o   = br_data_q;
   assign busy_o      = (state_q != S_IDLE);
   assign grant_idx_o = grant_q;

`ifdef BRLITE_ARB_TIMEOUT_EN
   assign timeout_o = timeout_q;
`else
   assign timeout_o = 1'b0;
`endif

endmodule
`default_nettype wire
